layer_input_serializer: RTL

- Upstream feeder for a layer of neuron instances.
- Captures the full parallel output vector of the previous layer in one cycle, then streams it one element per clock on the shared neuronIn/neuronValid bus seen by every neuron of the next layer.
- Double-buffered, so a new vector can arrive while the current one is streaming.
- Reports overflow when a third vector arrives before a buffer slot frees.

---
 rtl/layer_input_serializer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/layer_input_serializer.sv
`default_nettype none
// ============================================================================
// Module   : layer_input_serializer
// Purpose  : Captures a parallel layer output vector and streams it one
//            element per clock to the next layer, double-buffered.
// Revision : 1.0 - initial release
// ============================================================================
module layer_input_serializer #(
    parameter int numInputs  = 32,
    parameter int dataWidth  = 8,
    parameter int indexWidth = $clog2(numInputs)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [numInputs*dataWidth-1:0] dataIn,
    input  logic                           dataInValid,
    output logic [dataWidth-1:0]           dataOut,
    output logic                           dataOutValid,
    output logic                           firstOut,
    output logic                           lastOut,
    output logic [indexWidth-1:0]          elementIndex,
    output logic                           busy,
    output logic                           overflow
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [indexWidth-1:0] LAST_IDX = indexWidth'(numInputs - 1);
    localparam logic [indexWidth-1:0] ZERO_IDX = '0;

    state_t                         state_q, state_d;
    logic [numInputs*dataWidth-1:0] active_q, active_d;
    logic [numInputs*dataWidth-1:0] shadow_q, shadow_d;
    logic                           pending_q, pending_d;
    logic [dataWidth-1:0]           data_out_q, data_out_d;
    logic                           valid_q, valid_d;
    logic                           first_q, first_d;
    logic                           last_q, last_d;
    logic [indexWidth-1:0]          idx_q, idx_d;
    logic                           busy_q, busy_d;
    logic                           overflow_q, overflow_d;

    logic [dataWidth-1:0]           active_elem [numInputs];
    logic [indexWidth-1:0]          next_idx;
    logic                           last_cycle;

    generate
        for (genvar k = 0; k < numInputs; k++) begin : g_active_elem
            assign active_elem[k] = active_q[k*dataWidth +: dataWidth];
        end
    endgenerate

    assign next_idx   = idx_q + indexWidth'(1);
    assign last_cycle = (state_q == STREAM) && (idx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        first_d    = first_q;
        last_d     = last_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                first_d = 1'b0;
                last_d  = 1'b0;
                idx_d   = ZERO_IDX;
                if (dataInValid) begin
                    active_d   = dataIn;
                    data_out_d = dataIn[dataWidth-1:0];
                    valid_d    = 1'b1;
                    first_d    = 1'b1;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (!last_cycle) begin
                    idx_d      = next_idx;
                    data_out_d = active_elem[next_idx];
                    first_d    = 1'b0;
                    last_d     = (next_idx == LAST_IDX);
                    if (dataInValid) begin
                        if (!pending_q) begin
                            shadow_d  = dataIn;
                            pending_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end else if (pending_q) begin
                    // Shadow is consumed this cycle, so a new strobe may refill it.
                    active_d   = shadow_q;
                    data_out_d = shadow_q[dataWidth-1:0];
                    idx_d      = ZERO_IDX;
                    first_d    = 1'b1;
                    last_d     = 1'b0;
                    pending_d  = dataInValid;
                    if (dataInValid) begin
                        shadow_d = dataIn;
                    end
                end else if (dataInValid) begin
                    active_d   = dataIn;
                    data_out_d = dataIn[dataWidth-1:0];
                    idx_d      = ZERO_IDX;
                    first_d    = 1'b1;
                    last_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    idx_d   = ZERO_IDX;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == STREAM) || pending_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            active_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign dataOut      = data_out_q;
    assign dataOutValid = valid_q;
    assign firstOut     = first_q;
    assign lastOut      = last_q;
    assign elementIndex = idx_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;

endmodule
`default_nettype wire
